// File: rtl/mic_pkg.sv
// Shared types and default build constants for the PDM microphone capture block.
package mic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  localparam int MIC_HALF_DIV = 25;
  localparam int MIC_DECIM    = 64;
  localparam int MIC_WARMUP   = 1024;
  localparam int MIC_PCM_W    = 8;

endpackage

// File: rtl/mic_clk_gen.sv
// Microphone clock divider: mclk toggles every HALF_DIV enabled cycles, held low when
// disabled. Strobes flag the cycle whose closing edge makes mclk rise or fall.
module mic_clk_gen #(
  parameter int HALF_DIV = mic_pkg::MIC_HALF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic mclk,
  output logic rise_stb,
  output logic fall_stb
);

  localparam int CW = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          mclk_q, mclk_d;
  logic          tick;

  assign tick = en && (cnt_q == CNT_LAST);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d  = cnt_q;
    mclk_d = mclk_q;
    if (!en) begin
      cnt_d  = '0;
      mclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      mclk_d = ~mclk_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      mclk_q <= mclk_d;
    end
  end

  assign mclk     = mclk_q;
  assign rise_stb = tick & ~mclk_q;
  assign fall_stb = tick &  mclk_q;

endmodule

// File: rtl/mic_capture_ctrl.sv
// PDM microphone capture: drives mclk/lr, discards the warm-up period, then counts ones
// over DECIM samples per PCM word and offers each word on a valid/ready port.
module mic_capture_ctrl
  import mic_pkg::*;
#(
  parameter int HALF_DIV = MIC_HALF_DIV,
  parameter int DECIM    = MIC_DECIM,
  parameter int WARMUP   = MIC_WARMUP,
  parameter int PCM_W    = MIC_PCM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             lr_sel,
  input  logic             dataint,
  output logic             mclk,
  output logic             lr,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  input  logic             pcm_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);
  localparam logic [7:0]     BIT_LAST  = 8'(DECIM - 1);

  logic             rst_meta_q, rst_n_q;
  logic             din_meta_q, din_sync_q;
  state_e           state_q, state_d;
  logic             lr_q, lr_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic [PCM_W-1:0] acc_q, acc_d;
  logic [7:0]       bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0]   warm_cnt_q, warm_cnt_d;
  logic [PCM_W-1:0] pcm_data_q, pcm_data_d;
  logic             pcm_valid_q, pcm_valid_d;
  logic             gen_en, rise_stb, fall_stb;
  logic             sample_stb, word_done, xfer;
  logic [PCM_W-1:0] din_ext, word;

  // Reset asserts immediately but releases only after two clean clk edges.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  // A stop must silence mclk on the same edge the state returns to IDLE.
  assign gen_en = (state_q != ST_IDLE) && !stop;

  mic_clk_gen #(.HALF_DIV(HALF_DIV)) u_clk_gen (
    .clk      (clk),
    .rst_n    (rst_n_q),
    .en       (gen_en),
    .mclk     (mclk),
    .rise_stb (rise_stb),
    .fall_stb (fall_stb)
  );

  assign sample_stb = lr_q ? rise_stb : fall_stb;
  assign xfer       = pcm_valid_q && pcm_ready;
  assign din_ext    = {{(PCM_W-1){1'b0}}, din_sync_q};
  assign word       = acc_q + din_ext;

  always_comb begin
    state_d     = state_q;
    lr_d        = lr_q;
    overrun_d   = overrun_q;
    acc_d       = acc_q;
    bit_cnt_d   = bit_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    pcm_data_d  = pcm_data_q;
    pcm_valid_d = pcm_valid_q;
    word_done   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d    = ST_WARMUP;
          lr_d       = lr_sel;
          overrun_d  = 1'b0;
          acc_d      = '0;
          bit_cnt_d  = '0;
          warm_cnt_d = '0;
        end
      end
      ST_WARMUP: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (fall_stb) begin
          if (warm_cnt_q == WARM_LAST) state_d = ST_CAPTURE;
          else                         warm_cnt_d = warm_cnt_q + WCW'(1);
        end
      end
      ST_CAPTURE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (sample_stb) begin
          if (bit_cnt_q == BIT_LAST) begin
            word_done = 1'b1;
            acc_d     = '0;
            bit_cnt_d = '0;
          end else begin
            acc_d     = word;
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A word arriving while the previous one is still unaccepted is the one that is lost.
    if (word_done) begin
      if (!pcm_valid_q || xfer) begin
        pcm_data_d  = word;
        pcm_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      pcm_valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // NOTE: only control and datapath flops here; there are no memories needing no-reset treatment.
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      din_meta_q  <= 1'b0;
      din_sync_q  <= 1'b0;
      state_q     <= ST_IDLE;
      lr_q        <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      warm_cnt_q  <= '0;
      pcm_data_q  <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      din_meta_q  <= dataint;
      din_sync_q  <= din_meta_q;
      state_q     <= state_d;
      lr_q        <= lr_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      pcm_data_q  <= pcm_data_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign lr        = lr_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
  assign pcm_data  = pcm_data_q;
  assign pcm_valid = pcm_valid_q;

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Bench for mic_capture_ctrl: directed scenarios plus random traffic, every cycle compared
// against a timeline model built from edge counts since start.
module tb_mic_capture_ctrl;

  localparam int H  = 2;
  localparam int D  = 8;
  localparam int W  = 4;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, stop = 1'b0, lr_sel = 1'b0, dataint = 1'b0, pcm_ready = 1'b1;
  logic          mclk, lr, pcm_valid, busy, overrun;
  logic [PW-1:0] pcm_data;

  mic_capture_ctrl #(.HALF_DIV(H), .DECIM(D), .WARMUP(W), .PCM_W(PW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .lr_sel    (lr_sel),
    .dataint   (dataint),
    .mclk      (mclk),
    .lr        (lr),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .pcm_ready (pcm_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: t = edges since the accepted start. mclk is high in odd half-periods;
  // a sample is taken on every half-period boundary matching lr, using dataint as it was
  // two edges earlier, and only once t is past the WARMUP periods.
  bit m_busy, m_lr, m_ov, m_valid;
  int m_data, m_t, m_bits, m_sum;
  int din_hist[$] = '{0, 0};
  int md_din, md_word;
  bit md_done, md_rise, md_xfer;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 0; m_lr = 0; m_ov = 0; m_valid = 0;
      m_data = 0; m_t = 0; m_bits = 0; m_sum = 0;
      din_hist = '{0, 0};
    end else begin
      md_din = din_hist[0];
      void'(din_hist.pop_front());
      din_hist.push_back(int'(dataint));
      md_done = 0;
      md_word = 0;
      md_xfer = m_valid && pcm_ready;
      if (m_busy) begin
        if (stop) begin
          m_busy = 0;
        end else begin
          m_t++;
          if ((m_t % H) == 0 && m_t > 2 * H * W) begin
            md_rise = ((m_t / H) % 2) == 1;
            if (md_rise == m_lr) begin
              m_sum += md_din;
              m_bits++;
              if (m_bits == D) begin
                md_done = 1; md_word = m_sum; m_sum = 0; m_bits = 0;
              end
            end
          end
        end
      end else if (start && !stop) begin
        m_busy = 1; m_t = 0; m_lr = lr_sel; m_ov = 0; m_sum = 0; m_bits = 0;
      end
      if (md_done) begin
        if (!m_valid || md_xfer) begin m_data = md_word; m_valid = 1; end
        else m_ov = 1;
      end else if (md_xfer) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mclk",      int'(mclk),      int'(m_busy && ((m_t / H) % 2) == 1));
      check("busy",      int'(busy),      int'(m_busy));
      check("lr",        int'(lr),        int'(m_lr));
      check("pcm_valid", int'(pcm_valid), int'(m_valid));
      check("pcm_data",  int'(pcm_data),  m_data);
      check("overrun",   int'(overrun),   int'(m_ov));
    end
  end

  task automatic pulse(input bit s, input bit p, input bit l);
    @(negedge clk);
    start = s; stop = p; lr_sel = l;
    @(negedge clk);
    start = 0; stop = 0;
  endtask

  // mode 0: hold dataint, 1: random dataint
  task automatic run(input int n, input int mode, input int rdy_pct);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (mode == 1) dataint = 1'($urandom_range(0, 1));
      pcm_ready = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mclk"},  int'(mclk),      0);
    check({tag, "_busy"},  int'(busy),      0);
    check({tag, "_lr"},    int'(lr),        0);
    check({tag, "_valid"}, int'(pcm_valid), 0);
    check({tag, "_data"},  int'(pcm_data),  0);
    check({tag, "_ovr"},   int'(overrun),   0);
  endtask

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    int lat, guard, seen;

    #2 reset = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1;
    repeat (4) @(negedge clk);
    chk_en = 1;

    // Constant ones, right channel: first word of D after warm-up plus D samples.
    dataint = 1; pcm_ready = 1;
    pulse(1, 0, 1);
    lat = 0;
    while (!pcm_valid && lat < 200) begin @(negedge clk); lat++; end
    check("first_lat", lat, (2 * (W + D) - 1) * H);
    check("first_word", int'(pcm_data), D);
    pulse(1, 0, 0);                       // start while busy: ignored
    run(100, 0, 100);
    pulse(0, 1, 0);
    run(5, 0, 100);

    // Left channel, dataint toggling once per mclk period: every word is D/2.
    pulse(1, 0, 0);
    seen = 0;
    for (int i = 0; i < 160; i++) begin
      @(negedge clk);
      if (pcm_valid) begin seen++; check("toggle_word", int'(pcm_data), D / 2); end
      dataint = 1'((i / (2 * H)) % 2);
    end
    check("toggle_words_seen", int'(seen >= 3), 1);
    pulse(0, 1, 0);
    run(5, 0, 100);

    // Consumer stalls across two completions: first word held, overrun set.
    pcm_ready = 0;
    pulse(1, 0, 1);
    run(130, 1, 0);
    check("ovr_set", int'(overrun), 1);
    check("ovr_valid_held", int'(pcm_valid), 1);
    pulse(0, 1, 0);
    run(4, 1, 100);
    check("ovr_sticky_idle", int'(overrun), 1);
    pulse(1, 0, 1);
    check("ovr_cleared", int'(overrun), 0);
    run(60, 1, 100);
    pulse(0, 1, 0);
    run(6, 1, 100);

    // Stop with five bits accumulated in the first word.
    pulse(1, 0, 1);
    guard = 0;
    while (!(m_bits == 5 && m_t > 2 * H * W) && guard < 500) begin
      @(negedge clk); dataint = 1'($urandom_range(0, 1)); guard++;
    end
    check("stop5_reached", int'(guard < 500), 1);
    pulse(0, 1, 0);
    check("stop5_busy", int'(busy), 0);
    check("stop5_mclk", int'(mclk), 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (pcm_valid) seen++; end
    check("stop5_no_word", seen, 0);

    // Reset during capture with a word pending.
    pcm_ready = 0; dataint = 1;
    pulse(1, 0, 1);
    guard = 0;
    while (!pcm_valid && guard < 200) begin @(negedge clk); guard++; end
    check("rst_pending_valid", int'(pcm_valid), 1);
    #2 reset = 0;
    #1 check_all_zero("rst_mid");
    @(negedge clk);
    reset = 1;
    pcm_ready = 1;
    repeat (4) @(negedge clk);

    // Start and stop together in IDLE.
    pulse(1, 1, 1);
    check("startstop_busy", int'(busy), 0);
    run(4, 0, 100);
    check("startstop_busy_later", int'(busy), 0);

    // Random traffic.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      dataint   = 1'($urandom_range(0, 1));
      pcm_ready = ($urandom_range(0, 99) < 70);
      lr_sel    = 1'($urandom_range(0, 1));
      start     = ($urandom_range(0, 149) == 0);
      stop      = ($urandom_range(0, 399) == 0);
    end
    @(negedge clk);
    start = 0; stop = 0;
    run(5, 0, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
